pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
// - Drives the go/clear control inputs of the IF/ID and ID/EXE pipeline registers and the PC enable.
// - Detects load-use hazards between the ID and EXE instructions and flushes on taken branches.
// - Provides a halt/resume state machine for syscall halt.
// - Sits beside the pipeline; its outputs are sampled by the buffers at the same posedge.
// PARAMETERS
// - CNT_W   default 16   width of the stall/flush statistics counters
// PORTS
// - clk             in   1       system clock, all state updates on posedge
// - rst_n           in   1       reset, synchronous and active-low
// - id_instruction  in   32      instruction currently in ID (IF/ID output)
// - exe_instruction in   32      instruction currently in EXE (ID/EXE instruction output)
// - branch_taken    in   1       EXE-stage branch/jump resolved taken this cycle
// - halt_req        in   1       EXE-stage syscall-halt decoded this cycle
// - resume          in   1       level input from board button; rising edge resumes
// - pc_go           out  1       PC register enable
// - if_id_go        out  1       IF/ID go
// - if_id_clear     out  1       IF/ID clear (insert nop)
// - id_exe_go       out  1       ID/EXE go
// - id_exe_clear    out  1       ID/EXE clear (insert bubble)
// - halted          out  1       1 while in HALT state
// - stall_count     out  CNT_W   load-use stall cycles, saturating
// - flush_count     out  CNT_W   branch flush events, saturating
// BEHAVIOUR
// - Control outputs are combinational from state and inputs (zero latency). State, resume_q and counters are registered.
// - Load-use condition (lu):
//   - exe_instruction[31:26]==6'h23 (lw) and exe rt=exe_instruction[20:16]!=0
//   - and exe rt equals id rs=id_instruction[25:21] or id rt=id_instruction[20:16].
// - FSM states RUN(2'd0), HALT(2'd1), RESUME(2'd2); reset -> RUN.
// - resume_q registers resume; resume_rise = resume & ~resume_q; resume_q resets to 0.
// - RUN, priority halt_req > branch_taken > lu > normal:
//   - halt_req: pc_go=if_id_go=id_exe_go=0, clears=0; next state HALT.
//   - branch_taken: all go=1, if_id_clear=1, id_exe_clear=1; flush_count+1.
//   - lu: pc_go=0, if_id_go=0, id_exe_go=1, id_exe_clear=1, if_id_clear=0; stall_count+1.
//   - normal: all go=1, all clear=0.
// - HALT: all go=0, all clear=0, halted=1; resume_rise -> RESUME, otherwise stay.
// - RESUME: halt_req is ignored; branch_taken/lu/normal handled exactly as in RUN; next state RUN unconditionally.
//   - Lets the frozen halt instruction leave EXE.
// - Simultaneous branch_taken and halt_req in RUN: halt wins.
//   - Branch is re-evaluated in RESUME because EXE is frozen.
// - Counters saturate at {CNT_W{1'b1}}; no wrap.
// - rst_n=0 at any posedge, including mid-halt:
//   - state=RUN, resume_q=0, counters=0.
//   - Outputs during reset cycle: all go=1, clears=1 (pipeline registers load nop).
// - A lw with rt=0 never stalls.
// - At most one stall per load: after the bubble, EXE holds a nop.
// CONFIGURATION
// - PIPE_STATS_EN defined: stall_count/flush_count are implemented as above.
// - PIPE_STATS_EN undefined: no counter flops; stall_count and flush_count are tied to 0.
// TESTING
// - Reset: rst_n=0 for 2 cycles -> halted=0, all go=1, both clears=1, counters=0; state=RUN after release.
// - Load-use: EXE=lw $8 (0x8C080000), ID=add $9,$8,$10 (0x010A4820)
//   -> pc_go=0, if_id_go=0, id_exe_clear=1 for exactly 1 cycle; stall_count=1.
// - No hazard: EXE=lw $0 (0x8C000000), ID uses rs=0 -> no stall; EXE=lw $8, ID=add $9,$10,$11 -> no stall.
// - Branch plus hazard: branch_taken=1 with lu true -> if_id_clear=id_exe_clear=1, pc_go=1; flush_count=1, stall_count unchanged.
// - Halt/resume:
//   - halt_req=1 held 5 cycles -> all go=0, halted=1 from next cycle.
//   - resume 0->1 -> one RESUME cycle with all go=1 despite halt_req=1, then RUN, halted=0.
//   - resume held high does not retrigger.
// - Reset mid-halt / saturation:
//   - rst_n=0 while HALT -> RUN next cycle.
//   - CNT_W=2, 5 stalls -> stall_count=3.
//   - Without PIPE_STATS_EN, counts stay 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Pipeline hazard controller for a 5-stage MIPS-style core.
//                Drives PC enable and IF/ID, ID/EXE go/clear strobes, detects
//                load-use hazards, flushes on taken branches and implements a
//                syscall halt / button-resume state machine.
//                Optional statistics counters are built when the macro
//                PIPE_STATS_EN is defined; otherwise the count outputs are 0.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_instruction,
    input  logic [31:0]      exe_instruction,
    input  logic             branch_taken,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_go,
    output logic             if_id_go,
    output logic             if_id_clear,
    output logic             id_exe_go,
    output logic             id_exe_clear,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_HALT   = 2'd1;
    localparam logic [1:0] ST_RESUME = 2'd2;
    localparam logic [5:0] OP_LW     = 6'h23;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       resume_q;
    logic       resume_rise;
    logic       load_use;
    logic       run_active;
    logic [4:0] exe_rt;
    logic       unused_bits;

    // Only opcode/rt of EXE and rs/rt of ID matter for hazard detection.
    assign unused_bits = ^{id_instruction[31:26], id_instruction[15:0],
                           exe_instruction[25:21], exe_instruction[15:0]};

    assign exe_rt      = exe_instruction[20:16];
    assign load_use    = (exe_instruction[31:26] == OP_LW) && (exe_rt != 5'd0) &&
                         ((exe_rt == id_instruction[25:21]) ||
                          (exe_rt == id_instruction[20:16]));
    assign resume_rise = resume & ~resume_q;

    // RESUME ignores halt_req so the frozen syscall can finally leave EXE.
    assign run_active  = ((state_q == ST_RUN) && !halt_req) || (state_q == ST_RESUME);

    // Zero-latency control strobes and next-state selection.
    always_comb begin
        state_d      = state_q;
        pc_go        = 1'b1;
        if_id_go     = 1'b1;
        id_exe_go    = 1'b1;
        if_id_clear  = 1'b0;
        id_exe_clear = 1'b0;
        halted       = 1'b0;
        if (!rst_n) begin
            // Pipeline registers load nops while reset is held.
            if_id_clear  = 1'b1;
            id_exe_clear = 1'b1;
            state_d      = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (halt_req) begin
                        pc_go     = 1'b0;
                        if_id_go  = 1'b0;
                        id_exe_go = 1'b0;
                        state_d   = ST_HALT;
                    end
                end
                ST_HALT: begin
                    pc_go     = 1'b0;
                    if_id_go  = 1'b0;
                    id_exe_go = 1'b0;
                    halted    = 1'b1;
                    if (resume_rise) begin
                        state_d = ST_RESUME;
                    end
                end
                ST_RESUME: state_d = ST_RUN;
                default:   state_d = ST_RUN;
            endcase
            if (run_active) begin
                if (branch_taken) begin
                    // Flush both younger instructions; squashes any stall too.
                    if_id_clear  = 1'b1;
                    id_exe_clear = 1'b1;
                end else if (load_use) begin
                    // Hold PC and IF/ID, push a bubble into EXE.
                    pc_go        = 1'b0;
                    if_id_go     = 1'b0;
                    id_exe_clear = 1'b1;
                end
            end
        end
    end

    // State register and resume-button edge history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            resume_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume;
        end
    end

`ifdef PIPE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating event counters for stalls and flushes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (run_active && branch_taken && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
            if (run_active && !branch_taken && load_use &&
                (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule
`default_nettype wire
